// File: rtl/pea_ctx_sequencer.sv
// Context sequencer for the PE array: stores N_CTX contexts (one control word per PE
// plus an iteration count) and plays the selected ones onto the PE control buses.

module pea_ctx_lane #(
   parameter int N_CTX = 4,
   parameter int W     = 16,
   parameter int CTX_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             we_i,
   input  logic [CTX_W-1:0] wctx_i,
   input  logic [W-1:0]     wdata_i,
   input  logic             load_i,
   input  logic [CTX_W-1:0] lsel_i,
   input  logic             clr_i,
   output logic [W-1:0]     ctrl_o
);
   logic [N_CTX-1:0][W-1:0] mem_q;

   // Load reads the pre-write contents, so a same-cycle write is seen on the next load.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_q  <= '0;
         ctrl_o <= '0;
      end else begin
         if (we_i) mem_q[wctx_i] <= wdata_i;
         if (clr_i)       ctrl_o <= '0;
         else if (load_i) ctrl_o <= mem_q[lsel_i];
      end
   end
endmodule

module pea_ctx_sequencer #(
   parameter int N_PE          = 16,
   parameter int N_CFG_BITS_PE = 16,
   parameter int N_CTX         = 4,
   parameter int ITER_W        = 16,
   parameter int DRAIN_CYCLES  = 4,
   localparam int CTX_W        = $clog2(N_CTX),
   localparam int PE_W         = $clog2(N_PE)
) (
   input  logic                                    clk_i,
   input  logic                                    rst_n_i,
   input  logic                                    cfg_we_i,
   input  logic [CTX_W-1:0]                        cfg_ctx_i,
   input  logic [PE_W-1:0]                         cfg_pe_i,
   input  logic [N_CFG_BITS_PE-1:0]                cfg_word_i,
   input  logic                                    cfg_iter_we_i,
   input  logic [ITER_W-1:0]                       cfg_iter_i,
   output logic                                    cfg_err_o,
   input  logic                                    start_i,
   input  logic [CTX_W:0]                          n_ctx_i,
   input  logic                                    abort_i,
   input  logic                                    pea_ready_i,
   input  logic                                    pea_valid_i,
   output logic [N_PE-1:0][N_CFG_BITS_PE-1:0]      ctrl_pe_o,
   output logic [CTX_W-1:0]                        ctx_idx_o,
   output logic [ITER_W-1:0]                       iter_cnt_o,
   output logic                                    busy_o,
   output logic                                    done_o
);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CTX_W:0] MAX_CTX = (CTX_W+1)'(N_CTX);
   localparam logic [DW-1:0]  DRAIN_LD = DW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic                     we;
      logic                     iter_we;
      logic [CTX_W-1:0]         ctx;
      logic [PE_W-1:0]          pe;
      logic [N_CFG_BITS_PE-1:0] word;
      logic [ITER_W-1:0]        iter;
   } cfg_req_t;

   cfg_req_t                       cfg_req;
   state_t                         state_q, state_d;
   logic [CTX_W-1:0]               ctx_q, ctx_d;
   logic [ITER_W-1:0]              iter_q, iter_d;
   logic [DW-1:0]                  drain_q, drain_d;
   logic [CTX_W:0]                 nctx_q, nctx_d;
   logic                           done_d, busy_d, err_d;
   logic [N_CTX-1:0][ITER_W-1:0]   iter_mem_q;
   logic [ITER_W-1:0]              cur_cnt;
   logic                           wr_ok, beat, last_ctx;
   logic                           load, clr;
   logic [CTX_W-1:0]               lsel;
   logic [N_PE-1:0]                lane_we;

   assign cfg_req = '{we: cfg_we_i, iter_we: cfg_iter_we_i, ctx: cfg_ctx_i,
                      pe: cfg_pe_i, word: cfg_word_i, iter: cfg_iter_i};

   assign wr_ok    = (state_q == IDLE);
   assign beat     = pea_valid_i && pea_ready_i;
   assign cur_cnt  = iter_mem_q[ctx_q];
   assign last_ctx = ({1'b0, ctx_q} == (nctx_q - (CTX_W+1)'(1)));
   assign err_d    = !wr_ok && (cfg_req.we || cfg_req.iter_we);

   always_comb begin
      for (int i = 0; i < N_PE; i++)
         lane_we[i] = wr_ok && cfg_req.we && (cfg_req.pe == PE_W'(i));
   end

   for (genvar g = 0; g < N_PE; g++) begin : g_lane
      pea_ctx_lane #(
         .N_CTX (N_CTX),
         .W     (N_CFG_BITS_PE),
         .CTX_W (CTX_W)
      ) u_lane (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .we_i    (lane_we[g]),
         .wctx_i  (cfg_req.ctx),
         .wdata_i (cfg_req.word),
         .load_i  (load),
         .lsel_i  (lsel),
         .clr_i   (clr),
         .ctrl_o  (ctrl_pe_o[g])
      );
   end

   always_comb begin
      state_d = state_q;
      ctx_d   = ctx_q;
      iter_d  = iter_q;
      drain_d = drain_q;
      nctx_d  = nctx_q;
      done_d  = 1'b0;
      load    = 1'b0;
      clr     = 1'b0;
      lsel    = ctx_q;
      if (abort_i) begin
         state_d = IDLE;
         clr     = 1'b1;
         ctx_d   = '0;
         iter_d  = '0;
         drain_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (n_ctx_i == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = RUN;
                     load    = 1'b1;
                     lsel    = '0;
                     ctx_d   = '0;
                     iter_d  = '0;
                     nctx_d  = (n_ctx_i > MAX_CTX) ? MAX_CTX : n_ctx_i;
                  end
               end
            end
            RUN: begin
               iter_d = iter_q + ITER_W'(beat);
               // Count 0 leaves after a single cycle; otherwise the final beat exits.
               if (cur_cnt == '0 || (beat && iter_q == cur_cnt - ITER_W'(1))) begin
                  state_d = DRAIN;
                  clr     = 1'b1;
                  drain_d = DRAIN_LD;
               end
            end
            DRAIN: begin
               if (drain_q == '0) begin
                  if (last_ctx) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RUN;
                     ctx_d   = ctx_q + CTX_W'(1);
                     lsel    = ctx_q + CTX_W'(1);
                     load    = 1'b1;
                     iter_d  = '0;
                  end
               end else begin
                  drain_d = drain_q - DW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         ctx_q      <= '0;
         iter_q     <= '0;
         drain_q    <= '0;
         nctx_q     <= '0;
         done_o     <= 1'b0;
         busy_o     <= 1'b0;
         cfg_err_o  <= 1'b0;
         iter_mem_q <= '0;
      end else begin
         state_q   <= state_d;
         ctx_q     <= ctx_d;
         iter_q    <= iter_d;
         drain_q   <= drain_d;
         nctx_q    <= nctx_d;
         done_o    <= done_d;
         busy_o    <= busy_d;
         cfg_err_o <= err_d;
         if (wr_ok && cfg_req.iter_we) iter_mem_q[cfg_req.ctx] <= cfg_req.iter;
      end
   end

   assign ctx_idx_o  = ctx_q;
   assign iter_cnt_o = iter_q;
endmodule

// File: tb/tb_pea_ctx_sequencer.sv
// Directed bench for pea_ctx_sequencer: walks the sequencing, drain, abort, clamp and
// config-drop cases cycle by cycle against hand-computed expectations.

module tb_pea_ctx_sequencer;
   localparam int N_PE = 16;
   localparam int NB   = 16;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      cfg_we = 1'b0, cfg_iter_we = 1'b0;
   logic [1:0]                cfg_ctx = '0;
   logic [3:0]                cfg_pe = '0;
   logic [15:0]               cfg_word = '0, cfg_iter = '0;
   logic                      cfg_err;
   logic                      start = 1'b0, abort = 1'b0, ready = 1'b0, valid = 1'b0;
   logic [2:0]                n_ctx = '0;
   logic [N_PE-1:0][NB-1:0]   ctrl;
   logic [1:0]                ctx_idx;
   logic [15:0]               iter;
   logic                      busy, done;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   pea_ctx_sequencer dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .cfg_we_i(cfg_we), .cfg_ctx_i(cfg_ctx), .cfg_pe_i(cfg_pe), .cfg_word_i(cfg_word),
      .cfg_iter_we_i(cfg_iter_we), .cfg_iter_i(cfg_iter), .cfg_err_o(cfg_err),
      .start_i(start), .n_ctx_i(n_ctx), .abort_i(abort),
      .pea_ready_i(ready), .pea_valid_i(valid),
      .ctrl_pe_o(ctrl), .ctx_idx_o(ctx_idx), .iter_cnt_o(iter),
      .busy_o(busy), .done_o(done)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] ctxv(input logic [15:0] base, input logic [15:0] inc);
      logic [255:0] v;
      v = '0;
      for (int p = 0; p < N_PE; p++) v[p*16 +: 16] = base + 16'(p) * inc;
      return v;
   endfunction

   task automatic wr_word(input logic [1:0] c, input logic [3:0] p, input logic [15:0] w);
      cfg_we = 1'b1; cfg_ctx = c; cfg_pe = p; cfg_word = w;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic wr_ctx(input logic [1:0] c, input logic [15:0] base, input logic [15:0] inc);
      for (int p = 0; p < N_PE; p++) wr_word(c, 4'(p), base + 16'(p) * inc);
   endtask

   task automatic wr_iter(input logic [1:0] c, input logic [15:0] n);
      cfg_iter_we = 1'b1; cfg_ctx = c; cfg_iter = n;
      step();
      cfg_iter_we = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone, done_at, nchg;
      logic [1:0] prev;
      logic [255:0] cap;

      // reset
      repeat (3) step();
      chk("rst_ctrl", ctrl, '0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_iter", iter, 0);
      chk("rst_idx", ctx_idx, 0);
      chk("rst_err", cfg_err, 0);
      rst_n = 1'b1;
      step();

      // single context, 3 consecutive beats
      wr_ctx(0, 16'h0123, 16'h0000);
      wr_iter(0, 3);
      n_ctx = 1; start = 1'b1; step(); start = 1'b0;
      chk("s1_ctrl", ctrl, ctxv(16'h0123, 0));
      chk("s1_busy", busy, 1);
      chk("s1_iter0", iter, 0);
      valid = 1'b1; ready = 1'b1;
      step(); chk("s1_iter1", iter, 1);
      step(); chk("s1_iter2", iter, 2); chk("s1_ctrl2", ctrl, ctxv(16'h0123, 0));
      step(); chk("s1_iter3", iter, 3); chk("s1_nop", ctrl, '0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s1_drain_busy", busy, 1);
         chk("s1_drain_done", done, 0);
         chk("s1_drain_ctrl", ctrl, '0);
         chk("s1_drain_iter", iter, 3);
      end
      step(); chk("s1_done", done, 1); chk("s1_idle", busy, 0);
      valid = 1'b0;
      step(); chk("s1_done_pulse", done, 0);

      // two contexts, ready toggling
      wr_ctx(0, 16'h1000, 16'h0001); wr_iter(0, 2);
      wr_ctx(1, 16'h2000, 16'h0003); wr_iter(1, 1);
      n_ctx = 2; start = 1'b1; step(); start = 1'b0;
      valid = 1'b1; ready = 1'b0;
      step(); chk("s2_noready", iter, 0);
      ready = 1'b1; step(); chk("s2_beat1", iter, 1); chk("s2_ctrl0", ctrl, ctxv(16'h1000, 1));
      ready = 1'b0; step(); chk("s2_hold", iter, 1);
      ready = 1'b1; step(); chk("s2_beat2", iter, 2); chk("s2_nop", ctrl, '0);
      ready = 1'b0; step(); ready = 1'b1; step(); ready = 1'b0; step();
      chk("s2_gap_ctrl", ctrl, '0); chk("s2_gap_idx", ctx_idx, 0);
      step();
      chk("s2_idx1", ctx_idx, 1); chk("s2_ctrl1", ctrl, ctxv(16'h2000, 3)); chk("s2_iter_clr", iter, 0);
      step(); chk("s2_c1_noready", iter, 0); chk("s2_c1_ctrl", ctrl, ctxv(16'h2000, 3));
      ready = 1'b1; step(); chk("s2_c1_beat", iter, 1); chk("s2_c1_nop", ctrl, '0);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); chk("s2_drain_done", done, 0); end
      step(); chk("s2_done", done, 1); chk("s2_idle", busy, 0);
      valid = 1'b0;
      step(); chk("s2_done_once", done, 0);

      // zero-count middle context
      wr_iter(0, 1); wr_iter(1, 0);
      wr_ctx(2, 16'h3000, 16'h0011); wr_iter(2, 2);
      n_ctx = 3; valid = 1'b1; ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      chk("s3_iter0", iter, 0);
      step(); chk("s3_c0_nop", ctrl, '0);
      repeat (3) step();
      step(); chk("s3_idx1", ctx_idx, 1); chk("s3_ctrl1", ctrl, ctxv(16'h2000, 3));
      step(); chk("s3_c1_one_cycle", ctrl, '0); chk("s3_c1_busy", busy, 1);
      repeat (3) step();
      step(); chk("s3_idx2", ctx_idx, 2); chk("s3_ctrl2", ctrl, ctxv(16'h3000, 16'h0011));
      chk("s3_iter_clr", iter, 0);
      step(); chk("s3_c2_iter1", iter, 1);
      step(); chk("s3_c2_iter2", iter, 2); chk("s3_c2_nop", ctrl, '0);
      repeat (3) step();
      step(); chk("s3_done", done, 1);
      valid = 1'b0;
      step();

      // cfg write during RUN is dropped
      n_ctx = 1; start = 1'b1; step(); start = 1'b0;
      chk("s4_busy", busy, 1);
      cfg_we = 1'b1; cfg_ctx = 0; cfg_pe = 5; cfg_word = 16'hDEAD;
      step(); cfg_we = 1'b0;
      chk("s4_err", cfg_err, 1);
      step(); chk("s4_err_pulse", cfg_err, 0);
      valid = 1'b1; ready = 1'b1; step(); valid = 1'b0;
      chk("s4_nop", ctrl, '0);
      repeat (3) step();
      step(); chk("s4_done", done, 1);
      step();

      // abort with simultaneous start
      wr_iter(0, 5);
      chk("s5_idle_wr_noerr", cfg_err, 0);
      n_ctx = 1; start = 1'b1; step(); start = 1'b0;
      chk("s4_readback", ctrl, ctxv(16'h1000, 1));
      valid = 1'b1; ready = 1'b1;
      step(); step(); chk("s5_iter2", iter, 2);
      abort = 1'b1; start = 1'b1; valid = 1'b0;
      step(); abort = 1'b0; start = 1'b0;
      chk("s5_ab_busy", busy, 0); chk("s5_ab_ctrl", ctrl, '0);
      chk("s5_ab_iter", iter, 0); chk("s5_ab_idx", ctx_idx, 0); chk("s5_ab_done", done, 0);
      step(); chk("s5_ab_done2", done, 0); chk("s5_ab_busy2", busy, 0);
      start = 1'b1; step(); start = 1'b0;
      chk("s5_re_iter", iter, 0); chk("s5_re_ctrl", ctrl, ctxv(16'h1000, 1)); chk("s5_re_busy", busy, 1);
      valid = 1'b1; step(); chk("s5_re_beat", iter, 1);
      valid = 1'b0; abort = 1'b1; step(); abort = 1'b0;
      chk("s5_ab2_busy", busy, 0);

      // n_ctx = 0
      n_ctx = 0; start = 1'b1; step(); start = 1'b0;
      chk("s6_zero_done", done, 1); chk("s6_zero_busy", busy, 0);
      step(); chk("s6_zero_done2", done, 0); chk("s6_zero_busy2", busy, 0);

      // n_ctx = 7 clamps to 4; ctx3 word and count written in one cycle
      wr_iter(0, 0); wr_iter(1, 0); wr_iter(2, 0); wr_iter(3, 9);
      cfg_we = 1'b1; cfg_iter_we = 1'b1; cfg_ctx = 3; cfg_pe = 0;
      cfg_word = 16'h4444; cfg_iter = 0;
      step(); cfg_we = 1'b0; cfg_iter_we = 1'b0;
      n_ctx = 7; start = 1'b1; step(); start = 1'b0;
      ndone = 0; done_at = -1; nchg = 0; prev = ctx_idx; cap = '0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = c;
         end
         if (ctx_idx != prev) nchg++;
         prev = ctx_idx;
         if (c == 15) cap = ctrl;
      end
      chk("s6_clamp_ndone", ndone, 1);
      chk("s6_clamp_done_at", done_at, 20);
      chk("s6_clamp_ctx_steps", nchg, 3);
      chk("s6_clamp_last_idx", ctx_idx, 3);
      chk("s6_dual_wr_ctrl", cap, 256'h4444);

      // asynchronous reset mid-sequence clears state and storage
      n_ctx = 1; start = 1'b1; step(); start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("s7_async_busy", busy, 0); chk("s7_async_ctrl", ctrl, '0);
      rst_n = 1'b1;
      step();
      start = 1'b1; step(); start = 1'b0;
      chk("s7_storage_clr", ctrl, '0); chk("s7_busy", busy, 1);
      abort = 1'b1; step(); abort = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/pea_ctx_sequencer.md
# pea_ctx_sequencer

Context sequencer for the Processing Element Array (PEA). It stores up to N_CTX configuration contexts, each holding one control word per PE plus an iteration count. On start it drives the selected contexts onto the PE control buses one after another. Each context is held until the array has delivered the programmed number of output beats, followed by a NOP drain so in-flight valids clear before the next context is applied. It sits between the host configuration interface and the `ctrl_pe_i` inputs of every PE.

## Interface
- N_PE, 16: number of PEs driven.
- N_CFG_BITS_PE, 16: width of one PE control word. An all-zero word decodes as NOP in the PE.
- N_CTX, 4: number of stored contexts, ≥2. CTX_W = $clog2(N_CTX).
- ITER_W, 16: width of the per-context iteration count.
- DRAIN_CYCLES, 4: NOP cycles inserted after each context, ≥1.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cfg_we_i  in  1  write one PE control word.
- cfg_ctx_i  in  CTX_W  target context for the word or count write.
- cfg_pe_i  in  $clog2(N_PE)  target PE.
- cfg_word_i  in  N_CFG_BITS_PE  control word data.
- cfg_iter_we_i  in  1  write the iteration count of cfg_ctx_i.
- cfg_iter_i  in  ITER_W  iteration count data.
- cfg_err_o  out  1  one-cycle pulse: a cfg write was dropped.
- start_i  in  1  begin sequencing.
- n_ctx_i  in  CTX_W+1  number of contexts to run, starting at context 0.
- abort_i  in  1  stop immediately.
- pea_ready_i  in  1  array ready (back-pressure).
- pea_valid_i  in  1  array output valid.
- ctrl_pe_o  out  N_PE×N_CFG_BITS_PE  registered control words, one per PE.
- ctx_idx_o  out  CTX_W  context currently applied.
- iter_cnt_o  out  ITER_W  beats completed in the current context.
- busy_o  out  1  high whenever the sequencer is not IDLE.
- done_o  out  1  one-cycle pulse at the end of a sequence.

## Operation
- Storage:
  - Flop array of N_CTX×N_PE words plus N_CTX counts. Reset clears all entries to 0.
  - cfg_we_i and cfg_iter_we_i are accepted only in IDLE. In any other state the write is dropped and cfg_err_o pulses on the next cycle.
  - Both write strobes may be asserted in the same cycle; both writes take effect.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - On start_i with n_ctx_i≥1: load context 0 words into ctrl_pe_o, set ctx_idx_o=0 and iter_cnt_o=0, latch n_ctx_i, go to RUN.
  - On start_i with n_ctx_i=0: stay in IDLE and pulse done_o.
  - start_i in any other state is ignored.
- RUN:
  - A beat is a cycle with pea_valid_i && pea_ready_i. Each beat increments iter_cnt_o.
  - Exit to DRAIN when the stored count is 0 (after one RUN cycle), or on a beat where iter_cnt_o == count-1.
  - On exit, ctrl_pe_o becomes all-zero (NOP) and the drain counter loads DRAIN_CYCLES-1.
- DRAIN:
  - ctrl_pe_o holds 0 and the drain counter decrements every cycle, regardless of pea_ready_i.
  - At drain counter 0, if ctx_idx_o == latched n_ctx-1: go to IDLE and pulse done_o.
  - Otherwise: increment ctx_idx_o, load that context into ctrl_pe_o, clear iter_cnt_o, go to RUN.
- abort_i, in any state:
  - Next cycle: state IDLE, ctrl_pe_o=0, iter_cnt_o=0, ctx_idx_o=0, no done_o pulse.
  - abort_i takes priority over start_i in the same cycle.
- n_ctx_i > N_CTX is clamped to N_CTX.
- iter_cnt_o is ITER_W bits and never wraps, because it exits at count-1.

## Timing
- Reset values: ctrl_pe_o=0, ctx_idx_o=0, iter_cnt_o=0, busy_o=0, done_o=0, cfg_err_o=0.
- All outputs are registered.
- start_i sampled at edge t → ctrl_pe_o holds context 0 and busy_o=1 from t+1.
- Final beat at edge t → ctrl_pe_o=0 from t+1. DRAIN occupies cycles t+1 … t+DRAIN_CYCLES. The next context's words appear at t+DRAIN_CYCLES+1.
- done_o is high in the same cycle busy_o first returns to 0.
- A context with count 0 costs 1+DRAIN_CYCLES cycles.
- Beats arriving during DRAIN or IDLE are ignored.
- Reset asserted mid-sequence returns to IDLE asynchronously and clears storage.

## Test plan
- Program ctx0 (all PEs word 0x0123, count 3), start with n_ctx=1, 3 beats on consecutive cycles → ctrl=0x0123 for cycles 1–3, NOP for 4 cycles, done_o pulse at cycle 8, busy_o low.
- Two contexts (counts 2 and 1, distinct words), beats gated by pea_ready_i toggling 0/1 → only ready&&valid beats counted; ctx_idx_o goes 0→1 with a DRAIN_CYCLES NOP gap; one done_o pulse.
- ctx1 count 0, n_ctx=3 → ctx1 applied for exactly 1 cycle plus drain, then ctx2 runs.
- cfg_we_i during RUN → stored word unchanged (read back in a later run), cfg_err_o pulses once.
- abort_i in the middle of RUN with start_i asserted simultaneously → next cycle IDLE, ctrl=0, no done_o; a later start runs ctx0 from iter_cnt 0.
- start with n_ctx=0 → done_o pulse next cycle, busy_o never high; start with n_ctx=7 (N_CTX=4) → exactly 4 contexts run.
